ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: the send path to the keyboard, beside the existing PS/2 receive path.

---
 rtl/ps2_host_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send, bit clock-out
// on device falling edges and ACK check, driving the open-drain pads through output enables.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 3000,
  parameter int unsigned REQ_TIMEOUT    = 375000,
  parameter int unsigned XFER_TIMEOUT   = 50000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned MAX_REQ_XFER = (REQ_TIMEOUT > XFER_TIMEOUT) ? REQ_TIMEOUT : XFER_TIMEOUT;
  localparam int unsigned MAX_COUNT    = (MAX_REQ_XFER > INHIBIT_CYCLES) ? MAX_REQ_XFER : INHIBIT_CYCLES;
  localparam int unsigned TIMER_W      = $clog2(MAX_COUNT + 1);
  localparam int unsigned FILT_W       = $clog2(FILTER_LEN + 1);
  localparam int unsigned FRAME_W      = 10;
  localparam int unsigned IDX_W        = 4;

  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REQ_LAST     = TIMER_W'(REQ_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] XFER_LAST    = TIMER_W'(XFER_TIMEOUT - 1);
  localparam logic [FILT_W-1:0]  FILT_LAST    = FILT_W'(FILTER_LEN - 1);
  localparam logic [IDX_W-1:0]   LAST_FALL    = IDX_W'(9);

  localparam logic [1:0] ERR_REQ_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_XFER_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_NO_ACK       = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ_A,
    REQ,
    XFER,
    WAIT_IDLE,
    DONE,
    ERR
  } stateT;

  stateT              state;
  logic               clkMeta;
  logic               clkSync;
  logic               dataMeta;
  logic               dataSync;
  logic               clkFilt;
  logic               clkFall;
  logic [FILT_W-1:0]  filtCnt;
  logic [TIMER_W-1:0] timer;
  logic [FRAME_W-1:0] frame;
  logic [IDX_W-1:0]   fallCnt;

  // Two-stage synchronisers for both pad levels; idle bus level is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clkMeta  <= 1'b1;
      clkSync  <= 1'b1;
      dataMeta <= 1'b1;
      dataSync <= 1'b1;
    end else begin
      clkMeta  <= ps2_clk_in;
      clkSync  <= clkMeta;
      dataMeta <= ps2_data_in;
      dataSync <= dataMeta;
    end
  end

  // Clock level only changes after FILTER_LEN consecutive differing samples; fall is a 1-cycle strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clkFilt <= 1'b1;
      filtCnt <= '0;
      clkFall <= 1'b0;
    end else begin
      clkFall <= 1'b0;
      if (clkSync != clkFilt) begin
        if (filtCnt == FILT_LAST) begin
          clkFilt <= clkSync;
          filtCnt <= '0;
          clkFall <= clkFilt;
        end else begin
          filtCnt <= filtCnt + FILT_W'(1);
        end
      end else begin
        filtCnt <= '0;
      end
    end
  end

  // Transfer sequencer; every output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      err_code    <= 2'b00;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      timer       <= '0;
      frame       <= '0;
      fallCnt     <= '0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            frame       <= {1'b1, ~^tx_data, tx_data};
            state       <= INHIBIT;
            tx_ready    <= 1'b0;
            tx_busy     <= 1'b1;
            err_code    <= 2'b00;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            timer       <= '0;
          end
        end

        INHIBIT: begin
          if (timer == INHIBIT_LAST) begin
            state       <= REQ_A;
            ps2_data_oe <= 1'b1;
            timer       <= '0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        REQ_A: begin
          state      <= REQ;
          ps2_clk_oe <= 1'b0;
          timer      <= '0;
        end

        // Start bit is on the line; wait for the device to begin clocking.
        REQ: begin
          if (clkFall) begin
            state       <= XFER;
            ps2_data_oe <= ~frame[0];
            fallCnt     <= '0;
            timer       <= '0;
          end else if (timer == REQ_LAST) begin
            state       <= ERR;
            tx_err      <= 1'b1;
            err_code    <= ERR_REQ_TIMEOUT;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        // frame[0] is the bit on the line; the fall after the stop bit samples the ACK.
        XFER: begin
          timer <= timer + TIMER_W'(1);
          if (clkFall) begin
            if (fallCnt == LAST_FALL) begin
              ps2_data_oe <= 1'b0;
              if (!dataSync) begin
                state <= WAIT_IDLE;
              end else begin
                state    <= ERR;
                tx_err   <= 1'b1;
                err_code <= ERR_NO_ACK;
              end
            end else begin
              fallCnt     <= fallCnt + IDX_W'(1);
              ps2_data_oe <= ~frame[1];
              frame       <= {1'b1, frame[FRAME_W-1:1]};
            end
          end else if (timer == XFER_LAST) begin
            state       <= ERR;
            tx_err      <= 1'b1;
            err_code    <= ERR_XFER_TIMEOUT;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
          end
        end

        WAIT_IDLE: begin
          timer <= timer + TIMER_W'(1);
          if (clkFilt && dataSync) begin
            state   <= DONE;
            tx_done <= 1'b1;
          end else if (timer == XFER_LAST) begin
            state    <= ERR;
            tx_err   <= 1'b1;
            err_code <= ERR_XFER_TIMEOUT;
          end
        end

        DONE: begin
          state    <= IDLE;
          tx_busy  <= 1'b0;
          tx_ready <= 1'b1;
        end

        ERR: begin
          state       <= IDLE;
          tx_busy     <= 1'b0;
          tx_ready    <= 1'b1;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model clocking frames, reference line values
// computed from the byte's bits and parity.
module tb_ps2_host_tx;

  localparam int unsigned INH   = 10;
  localparam int unsigned REQT  = 200;
  localparam int unsigned XFERT = 2000;
  localparam int unsigned FL    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady, txBusy, txDone, txErr;
  logic [1:0] errCode;
  logic       ps2ClkIn, ps2DataIn, ps2ClkOe, ps2DataOe;
  logic       devClk, devData;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         doneCnt = 0;
  int         errCnt = 0;
  int         errCyc = 0;
  logic [1:0] lastErrCode = 2'b00;
  logic [1:0] errOe = 2'b00;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_TIMEOUT   (REQT),
    .XFER_TIMEOUT  (XFERT),
    .FILTER_LEN    (FL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (txData),
    .tx_valid   (txValid),
    .tx_ready   (txReady),
    .tx_busy    (txBusy),
    .tx_done    (txDone),
    .tx_err     (txErr),
    .err_code   (errCode),
    .ps2_clk_in (ps2ClkIn),
    .ps2_data_in(ps2DataIn),
    .ps2_clk_oe (ps2ClkOe),
    .ps2_data_oe(ps2DataOe)
  );

  always #5 clk = ~clk;

  // Wired-AND open-drain bus between host enables and device drivers.
  assign ps2ClkIn  = ps2ClkOe ? 1'b0 : devClk;
  assign ps2DataIn = ps2DataOe ? 1'b0 : devData;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (txDone) doneCnt = doneCnt + 1;
    if (txErr) begin
      errCnt      = errCnt + 1;
      errCyc      = cyc;
      lastErrCode = errCode;
      errOe       = {ps2ClkOe, ps2DataOe};
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Expected data enable at device fall 1..10: data bits LSB first, odd parity, released stop.
  function automatic logic refOe(input logic [7:0] d, input int fall);
    int ones = 0;
    for (int b = 0; b < 8; b++) ones += int'(d[b]);
    if (fall <= 8) return !d[fall-1];
    if (fall == 9) return (ones % 2) != 0;
    return 1'b0;
  endfunction

  task automatic startTx(input logic [7:0] d);
    int n = 0;
    while (!txReady && n < 500) begin
      tick();
      n++;
    end
    check1("ready_before_accept", txReady, 1'b1);
    txData  = d;
    txValid = 1'b1;
    tick();
    txValid = 1'b0;
    txData  = 8'($urandom);
  endtask

  task automatic waitReq();
    int n = 0;
    while (ps2ClkOe && n < 500) begin
      tick();
      n++;
    end
    check1("req_clk_released", ps2ClkOe, 1'b0);
    check1("req_start_bit", ps2DataOe, 1'b1);
  endtask

  task automatic deviceFrame(input logic [7:0] d, input int nFalls, input bit ack, input int halfP);
    for (int i = 1; i <= nFalls; i++) begin
      devClk = 1'b0;
      tick(halfP);
      if (i <= 10) check1($sformatf("fall%0d_data_oe", i), ps2DataOe, refOe(d, i));
      devClk = 1'b1;
      if (i == 10 && ack) devData = 1'b0;
      tick(halfP);
    end
    devData = 1'b1;
  endtask

  task automatic waitEvent(input int d0, input int e0, input int budget);
    int n = 0;
    while (doneCnt == d0 && errCnt == e0 && n < budget) begin
      tick();
      n++;
    end
    check1("event_within_budget", (doneCnt != d0) || (errCnt != e0), 1'b1);
  endtask

  task automatic goodTransfer(input logic [7:0] d, input int halfP);
    int d0 = doneCnt;
    int e0 = errCnt;
    startTx(d);
    check1("clk_oe_after_accept", ps2ClkOe, 1'b1);
    check1("busy_after_accept", txBusy, 1'b1);
    waitReq();
    tick(4);
    deviceFrame(d, 11, 1'b1, halfP);
    waitEvent(d0, e0, 200);
    checkInt("done_pulses", doneCnt - d0, 1);
    checkInt("err_pulses", errCnt - e0, 0);
    check1("busy_during_done", txBusy, 1'b1);
    tick();
    check1("busy_after_done", txBusy, 1'b0);
    check1("ready_after_done", txReady, 1'b1);
  endtask

  initial begin
    logic [7:0] d;
    int         n, d0, e0, relCyc, fallCyc;

    reset   = 1'b0;
    txValid = 1'b0;
    txData  = 8'h00;
    devClk  = 1'b1;
    devData = 1'b1;
    tick(3);
    check1("rst_ready", txReady, 1'b1);
    check1("rst_busy", txBusy, 1'b0);
    check1("rst_done", txDone, 1'b0);
    check1("rst_err", txErr, 1'b0);
    checkInt("rst_err_code", int'(errCode), 0);
    check1("rst_clk_oe", ps2ClkOe, 1'b0);
    check1("rst_data_oe", ps2DataOe, 1'b0);
    reset = 1'b1;
    tick(5);

    // 0xED with ACK; err_code stays clear.
    goodTransfer(8'hED, 10);
    checkInt("ed_err_code", int'(errCode), 0);

    // 0xF4: clock inhibit width, then parity driven low.
    d0 = doneCnt;
    startTx(8'hF4);
    n = 0;
    while (ps2ClkOe && n < 50) begin
      n++;
      tick();
    end
    checkInt("f4_clk_oe_cycles", n, 11);
    check1("f4_start_bit", ps2DataOe, 1'b1);
    tick(4);
    deviceFrame(8'hF4, 11, 1'b1, 12);
    waitEvent(d0, errCnt, 200);
    checkInt("f4_done", doneCnt - d0, 1);

    // Device never clocks: request timeout.
    e0 = errCnt;
    startTx(8'($urandom));
    waitReq();
    relCyc = cyc;
    waitEvent(doneCnt, e0, 400);
    checkInt("req_to_err_cycles", errCyc - relCyc, int'(REQT));
    checkInt("req_err_code", int'(lastErrCode), 1);
    checkInt("req_err_oe", int'(errOe), 0);
    tick();
    check1("req_ready_after_err", txReady, 1'b1);

    // No ACK from device.
    d0 = doneCnt;
    e0 = errCnt;
    d  = 8'($urandom);
    startTx(d);
    waitReq();
    tick(4);
    deviceFrame(d, 11, 1'b0, 12);
    waitEvent(d0, e0, 200);
    tick(20);
    checkInt("noack_err", errCnt - e0, 1);
    checkInt("noack_code", int'(lastErrCode), 3);
    checkInt("noack_no_done", doneCnt - d0, 0);

    // Device stops after 5 falls: transfer timeout.
    e0 = errCnt;
    d  = 8'($urandom);
    startTx(d);
    waitReq();
    tick(4);
    fallCyc = cyc;
    deviceFrame(d, 5, 1'b0, 10);
    waitEvent(doneCnt, e0, 3000);
    checkInt("xfer_code", int'(lastErrCode), 2);
    check1("xfer_timeout_window", (errCyc - fallCyc >= int'(XFERT)) && (errCyc - fallCyc <= int'(XFERT) + 10), 1'b1);

    // Glitch during request must not start the transfer.
    d = 8'($urandom) | 8'h01;
    d0 = doneCnt;
    startTx(d);
    waitReq();
    tick(6);
    devClk = 1'b0;
    tick();
    devClk = 1'b1;
    tick(10);
    check1("glitch_no_fall_data", ps2DataOe, 1'b1);
    check1("glitch_no_fall_clk", ps2ClkOe, 1'b0);
    deviceFrame(d, 11, 1'b1, 10);
    waitEvent(d0, errCnt, 200);
    checkInt("glitch_done", doneCnt - d0, 1);

    // Reset in the middle of bit 4, then 0xFF resends cleanly.
    d = 8'($urandom);
    startTx(d);
    waitReq();
    tick(4);
    deviceFrame(d, 4, 1'b0, 10);
    devClk = 1'b0;
    tick(10);
    check1("bit4_data_oe", ps2DataOe, refOe(d, 5));
    reset = 1'b0;
    #1;
    check1("midrst_clk_oe", ps2ClkOe, 1'b0);
    check1("midrst_data_oe", ps2DataOe, 1'b0);
    check1("midrst_busy", txBusy, 1'b0);
    check1("midrst_ready", txReady, 1'b1);
    devClk = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(5);
    goodTransfer(8'hFF, 10);

    // Random bytes and device clock rates.
    for (int k = 0; k < 4; k++) goodTransfer(8'($urandom), int'($urandom_range(8, 20)));

    // tx_valid held while busy is only re-accepted back in IDLE.
    d  = 8'($urandom);
    d0 = doneCnt;
    e0 = errCnt;
    txData  = d;
    txValid = 1'b1;
    tick();
    txData = ~d;
    waitReq();
    check1("held_ready_low", txReady, 1'b0);
    tick(4);
    deviceFrame(d, 11, 1'b1, 10);
    waitEvent(d0, e0, 200);
    checkInt("held_done", doneCnt - d0, 1);
    tick();
    check1("held_ready_idle", txReady, 1'b1);
    tick();
    check1("held_reaccept", ps2ClkOe, 1'b1);
    txValid = 1'b0;
    waitReq();
    waitEvent(doneCnt, e0, 400);
    checkInt("held_timeout_code", int'(lastErrCode), 1);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
